// File: rtl/ram_rd_stream.sv
//==============================================================================
// Module   : ram_rd_stream
// Purpose  : Sweeps a block-RAM address range and streams the words out on a
//            valid/ready interface, hiding the RAM's one-cycle read latency.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module ram_rd_stream #(
    parameter int DATAWIDTH = 18,
    parameter int ADDRWIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset_l,
    input  logic                 start,
    input  logic [ADDRWIDTH-1:0] start_addr,
    input  logic [ADDRWIDTH:0]   len,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic [ADDRWIDTH-1:0] rd_addr,
    input  logic [DATAWIDTH-1:0] rd_data,
    output logic [DATAWIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int c_FDEPTH = 4;
    localparam int c_PTR_W  = $clog2(c_FDEPTH);
    localparam int c_CNT_W  = c_PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t               r_state;
    logic [ADDRWIDTH:0]   r_remaining;
    logic [ADDRWIDTH-1:0] r_addr;
    logic                 r_pend;
    logic                 r_busy;
    logic                 r_done;
    logic [DATAWIDTH-1:0] r_fifo [c_FDEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;

    logic                 w_pop;
    logic                 w_issue;
    logic [c_CNT_W-1:0]   w_credit;
    logic [c_CNT_W-1:0]   w_count_nxt;

    // r_pend marks that rd_data carries a word we asked for; it is the only
    // read in flight, and it is charged against FIFO space before issuing more.
    assign w_credit    = r_count + c_CNT_W'(r_pend);
    assign w_issue     = (r_state == S_RUN) && (w_credit < c_CNT_W'(c_FDEPTH));
    assign w_pop       = (r_count != '0) && out_ready;
    assign w_count_nxt = r_count + c_CNT_W'(r_pend) - c_CNT_W'(w_pop);

    always_ff @(posedge clk) begin
        if (r_pend) begin
            r_fifo[r_wr_ptr] <= rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_addr      <= '0;
            r_pend      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
        end else if (abort) begin
            r_state  <= S_IDLE;
            r_pend   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_done  <= 1'b0;
            r_pend  <= w_issue;
            r_count <= w_count_nxt;
            if (r_pend) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_issue) begin
                r_addr      <= r_addr + 1'b1;
                r_remaining <= r_remaining - 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (len == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state     <= S_RUN;
                            r_busy      <= 1'b1;
                            r_addr      <= start_addr;
                            r_remaining <= len;
                        end
                    end
                end
                S_RUN: begin
                    if (w_issue && (r_remaining == (ADDRWIDTH+1)'(1))) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Finish on the edge that empties the pipe so done lines
                    // up with the cycle right after the final handshake.
                    if (w_count_nxt == '0) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign rd_addr   = r_addr;
    assign out_valid = (r_count != '0);
    assign out_data  = r_fifo[r_rd_ptr];

endmodule

`default_nettype wire

// File: tb/tb_ram_rd_stream.sv
//==============================================================================
// Module   : tb_ram_rd_stream
// Purpose  : Randomized self-checking bench for ram_rd_stream against a
//            queue-based model of the expected word stream and timing.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ram_rd_stream;

    localparam int DW = 18;
    localparam int AW = 5;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset_l = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          out_ready = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW:0]   len = '0;
    logic          busy;
    logic          done;
    logic          out_valid;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] out_data;
    logic [DW-1:0] ram [DEPTH];

    int n_checks = 0;
    int n_pass   = 0;

    ram_rd_stream #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) dut (
        .clk        (clk),
        .reset_l    (reset_l),
        .start      (start),
        .start_addr (start_addr),
        .len        (len),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    // Registered-read block RAM seen by the DUT
    always @(posedge clk) rd_data <= ram[rd_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transfer: expected words are RAM[(sa+i) mod DEPTH]; first word is
    // valid two cycles after the start edge and the stream never bubbles.
    task automatic do_xfer(input int sa, input int n, input int rdy_pct,
                           input int abort_at, input bit pester);
        logic [DW-1:0] expq[$];
        logic [DW-1:0] prev_data;
        bit            prev_stall;
        bit            last_prev;
        bit            exp_v;
        int            got;
        prev_stall = 1'b0;
        last_prev  = 1'b0;
        prev_data  = '0;
        got        = 0;
        for (int i = 0; i < n; i++) expq.push_back(ram[(sa + i) % DEPTH]);
        start      = 1'b1;
        start_addr = AW'(sa);
        len        = (AW+1)'(n);
        out_ready  = 1'b0;
        tick();
        start = 1'b0;
        if (n == 0) begin
            check("len0_done", 32'(done), 32'(1));
            check("len0_busy", 32'(busy), 32'(0));
            check("len0_valid", 32'(out_valid), 32'(0));
            tick();
            check("len0_done_once", 32'(done), 32'(0));
            check("len0_valid_after", 32'(out_valid), 32'(0));
            return;
        end
        check("rd_addr_first", 32'(rd_addr), 32'(sa));
        for (int cyc = 0; cyc < 2000; cyc++) begin
            check("done", 32'(done), 32'(last_prev));
            if (last_prev) begin
                check("busy_at_done", 32'(busy), 32'(0));
                check("valid_at_done", 32'(out_valid), 32'(0));
                tick();
                check("done_one_cycle", 32'(done), 32'(0));
                return;
            end
            exp_v = (cyc >= 2) && (got < n);
            check("busy", 32'(busy), 32'(1));
            check("valid", 32'(out_valid), 32'(exp_v));
            if (prev_stall) check("hold", 32'(out_data), 32'(prev_data));
            if (exp_v && got == abort_at) begin
                abort     = 1'b1;
                start     = 1'b1;
                out_ready = 1'(($urandom_range(1)));
                tick();
                abort = 1'b0;
                start = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    check("abort_busy", 32'(busy), 32'(0));
                    check("abort_valid", 32'(out_valid), 32'(0));
                    check("abort_done", 32'(done), 32'(0));
                    tick();
                end
                return;
            end
            out_ready  = ($urandom_range(99) < rdy_pct);
            start      = pester && ($urandom_range(3) == 0);
            start_addr = AW'($urandom);
            len        = (AW+1)'($urandom_range(1, DEPTH));
            last_prev  = 1'b0;
            if (exp_v && out_ready) begin
                check("data", 32'(out_data), 32'(expq.pop_front()));
                got++;
                last_prev = (got == n);
            end
            prev_stall = exp_v && !out_ready;
            prev_data  = out_data;
            tick();
            start = 1'b0;
        end
        check("timeout", 32'(0), 32'(1));
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = DW'(i + 'h100);

        tick();
        tick();
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_valid", 32'(out_valid), 32'(0));
        check("rst_rd_addr", 32'(rd_addr), 32'(0));
        reset_l = 1'b1;
        tick();

        do_xfer(3, 5, 100, -1, 1'b0);
        do_xfer(30, 4, 100, -1, 1'b0);

        for (int i = 0; i < DEPTH; i++) ram[i] = {13'($urandom), 5'(i)};

        do_xfer(12, 8, 50, -1, 1'b0);
        do_xfer(int'($urandom_range(0, DEPTH-1)), 8, 50, -1, 1'b1);
        do_xfer(9, 0, 100, -1, 1'b0);
        do_xfer(17, DEPTH, 100, -1, 1'b0);
        do_xfer(int'($urandom_range(0, DEPTH-1)), DEPTH, 40, -1, 1'b1);
        do_xfer(4, 10, 100, 2, 1'b0);
        do_xfer(20, 2, 100, -1, 1'b0);

        // abort wins over start while idle
        start      = 1'b1;
        abort      = 1'b1;
        start_addr = AW'(1);
        len        = (AW+1)'(3);
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("abort_vs_start_busy", 32'(busy), 32'(0));
        check("abort_vs_start_done", 32'(done), 32'(0));
        tick();
        check("abort_vs_start_valid", 32'(out_valid), 32'(0));

        // reset mid-transfer
        start      = 1'b1;
        start_addr = AW'(5);
        len        = (AW+1)'(10);
        out_ready  = 1'b0;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        reset_l = 1'b0;
        tick();
        check("midrst_busy", 32'(busy), 32'(0));
        check("midrst_done", 32'(done), 32'(0));
        check("midrst_valid", 32'(out_valid), 32'(0));
        check("midrst_rd_addr", 32'(rd_addr), 32'(0));
        reset_l = 1'b1;
        tick();
        check("midrst_idle", 32'(busy), 32'(0));

        for (int t = 0; t < 6; t++) begin
            do_xfer(int'($urandom_range(0, DEPTH-1)), int'($urandom_range(1, DEPTH)),
                    int'($urandom_range(20, 100)), -1, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
